// File: rtl/seq_div.sv
// seq_div: multi-cycle radix-2 restoring divider with start/busy/done handshake.
// Optional two's-complement mode is built only when DIV_SIGNED_EN is defined.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             inRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iQ,
    input  logic [WIDTH-1:0] iD,
    input  logic             iSigned,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oR,
    output logic             oDivZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] d_mag;
    logic             last_step;
    logic             div_zero_in;

`ifdef DIV_SIGNED_EN
    logic             sgn;
    logic             neg_q;
    logic             neg_r;
    logic             a_neg;
    logic             d_neg;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
`else
    logic             unused_signed;
    assign unused_signed = iSigned;
`endif

    assign last_step   = (cnt == CNT_W'(1));
    assign div_zero_in = (iD == '0);

    // one restoring step: shift {rem,quo}, subtract divisor, keep if non-negative
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, div};
        step_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

`ifdef DIV_SIGNED_EN
    // operand magnitudes on entry and sign correction of the final result
    always_comb begin
        a_neg = iSigned & iQ[WIDTH-1];
        d_neg = iSigned & iD[WIDTH-1];
        a_mag = a_neg ? -iQ : iQ;
        d_mag = d_neg ? -iD : iD;
        fix_q = neg_q ? -quo : quo;
        fix_r = neg_r ? -rem : rem;
    end
`else
    // unsigned only: operands are used as given
    always_comb begin
        a_mag = iQ;
        d_mag = iD;
    end
`endif

    // state register
    always_ff @(posedge iClk) begin
        if (!inRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    state_nxt = div_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
`ifdef DIV_SIGNED_EN
                    state_nxt = sgn ? FIX : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIX:  state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from the state register
    always_comb begin
        oBusy = 1'b0;
        oDone = 1'b0;
        unique case (state)
            CALC:    oBusy = 1'b1;
            FIX:     oBusy = 1'b1;
            DONE:    oDone = 1'b1;
            default: oBusy = 1'b0;
        endcase
    end

    // datapath and result registers; results change only on entry to DONE
    always_ff @(posedge iClk) begin
        if (!inRst) begin
            rem      <= '0;
            quo      <= '0;
            div      <= '0;
            cnt      <= '0;
            oQ       <= '0;
            oR       <= '0;
            oDivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn      <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (div_zero_in) begin
                            oQ       <= '1;
                            oR       <= iQ;
                            oDivZero <= 1'b1;
                        end else begin
                            rem <= '0;
                            quo <= a_mag;
                            div <= d_mag;
                            cnt <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                            sgn   <= iSigned;
                            neg_q <= a_neg ^ d_neg;
                            neg_r <= a_neg;
`endif
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt - CNT_W'(1);
`ifdef DIV_SIGNED_EN
                    if (last_step && !sgn) begin
`else
                    if (last_step) begin
`endif
                        oQ       <= step_quo;
                        oR       <= step_rem;
                        oDivZero <= 1'b0;
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    oQ       <= fix_q;
                    oR       <= fix_r;
                    oDivZero <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div at WIDTH=32.
// Directed vectors; expected results queued at issue, checked by a monitor.
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .iClk    (clk),
        .inRst   (rst_n),
        .iStart  (start),
        .iQ      (a),
        .iD      (b),
        .iSigned (sgn),
        .oBusy   (busy),
        .oDone   (done),
        .oQ      (q),
        .oR      (r),
        .oDivZero(dz)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // monitor: every oDone pops one expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got q=%h r=%h want no done", q, r);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", q, mon_e.q);
                chk("remainder", r, mon_e.r);
                chk("divzero", W'(dz), W'(mon_e.dz));
                chk("latency", W'(cyc - mon_e.t0 + 1), W'(mon_e.lat));
                chk("busy_in_done", W'(busy), '0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] qa, input logic [W-1:0] db,
                         input logic s, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edz,
                         input int elat);
        exp_t e;
        @(negedge clk);
        a     = qa;
        b     = db;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.lat = elat;
        e.t0  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_q"}, q, '0);
        chk({name, "_r"}, r, '0);
        chk({name, "_dz"}, W'(dz), '0);
        chk({name, "_busy"}, W'(busy), '0);
        chk({name, "_done"}, W'(done), '0);
    endtask

    logic [W-1:0] vq[6] = '{32'd100, 32'd5, 32'hFFFFFFFF,
                            32'h80000000, 32'd12345678, 32'd0};
    logic [W-1:0] vd[6] = '{32'd7, 32'd9, 32'hFFFFFFFF,
                            32'd3, 32'd1000, 32'd5};
    logic [W-1:0] vxq[6] = '{32'd14, 32'd0, 32'd1,
                             32'd715827882, 32'd12345, 32'd0};
    logic [W-1:0] vxr[6] = '{32'd2, 32'd5, 32'd0,
                             32'd2, 32'd678, 32'd0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        issue(32'd447, 32'd12, 1'b0, 32'd37, 32'd3, 1'b0, W + 1);
        @(negedge clk);
        chk("busy_cycle1", W'(busy), W'(1));
        wait_empty();
        repeat (3) @(negedge clk);
        chk("hold_q", q, 32'd37);

        issue(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, W + 1);
        @(negedge clk);
        a = 32'h1234;
        b = 32'd0;
        repeat (5) @(negedge clk);
        chk("undisturbed_q", q, 32'd37);
        chk("undisturbed_r", r, 32'd3);
        wait_empty();

        issue(32'd1, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 1);
        wait_empty();
        issue(32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
        wait_empty();
        issue(32'h07000000, 32'h07FFFFFF, 1'b0, 32'd0, 32'h07000000, 1'b0, W + 1);
        wait_empty();

        for (int i = 0; i < 6; i++) begin
            issue(vq[i], vd[i], 1'b0, vxq[i], vxr[i], 1'b0, W + 1);
            wait_empty();
        end

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W + 1);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("start_in_done_busy", W'(busy), '0);
        chk("start_in_done_q", q, 32'd14);

        @(negedge clk);
        a     = 32'd3000;
        b     = 32'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 9) @(negedge clk);
        a     = 32'd9;
        b     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_ignore_start", W'(busy), W'(1));
        while (cyc < t0 + 19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("abort_reset");
        repeat (40) @(negedge clk);
        chk("abort_q", q, '0);

        issue(32'd30, 32'd2, 1'b0, 32'd15, 32'd0, 1'b0, W + 1);
        wait_empty();

`ifdef DIV_SIGNED_EN
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, W + 2);
        wait_empty();
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, W + 2);
        wait_empty();
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, W + 2);
        wait_empty();
        issue(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
        wait_empty();
        issue(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, W + 1);
        wait_empty();
`else
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0, W + 1);
        wait_empty();
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
